// File: rtl/key_ctrl.sv
// key_ctrl: per-key debounce and held/auto-repeat sequencer for active-low
// pushbuttons. Each channel runs its own FSM and counter. All outputs are
// registered. One key's presses toggle a latched pause level.
module key_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int PAUSE_KEY       = 1,
    parameter int CW              = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_n_out,
    output logic [NUM_KEYS-1:0] press_o,
    output logic [NUM_KEYS-1:0] release_o,
    output logic [NUM_KEYS-1:0] repeat_o,
    output logic                pause_n_out,
    output logic                any_key
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_CHK,
        S_HELD,
        S_REPEAT,
        S_RELEASE_CHK
    } state_e;

    localparam logic [CW-1:0] DEB_C    = CW'(DEBOUNCE_CYCLES);
    localparam int            RD_LAST  = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam logic [CW-1:0] RD_C     = CW'(RD_LAST);
    localparam logic [CW-1:0] RP_C     = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    state_e              state_q [NUM_KEYS];
    state_e              state_d [NUM_KEYS];
    logic [CW-1:0]       cnt_q   [NUM_KEYS];
    logic [CW-1:0]       cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_n_q, key_n_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic                pause_n_q, pause_n_d;
    logic                any_key_q, any_key_d;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + ONE_C;
    endfunction

    // Next-state, counter and strobe decode for every channel.
    always_comb begin
        key_n_d   = '1;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                S_IDLE: begin
                    if (!key_n_in[k]) begin
                        if (ONE_C >= DEB_C) begin
                            state_d[k]  = S_HELD;
                            cnt_d[k]    = '0;
                            press_d[k]  = 1'b1;
                            repeat_d[k] = 1'b1;
                        end else begin
                            state_d[k] = S_PRESS_CHK;
                            cnt_d[k]   = ONE_C;
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (key_n_in[k]) begin
                        state_d[k] = S_IDLE;
                        cnt_d[k]   = '0;
                    end else if (sat_inc(cnt_q[k]) >= DEB_C) begin
                        state_d[k]  = S_HELD;
                        cnt_d[k]    = '0;
                        press_d[k]  = 1'b1;
                        repeat_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = sat_inc(cnt_q[k]);
                    end
                end
                S_HELD, S_REPEAT: begin
                    if (key_n_in[k]) begin
                        // Leaving the hold discards any pending repeat timing.
                        if (ONE_C >= DEB_C) begin
                            state_d[k]   = S_IDLE;
                            cnt_d[k]     = '0;
                            release_d[k] = 1'b1;
                        end else begin
                            state_d[k] = S_RELEASE_CHK;
                            cnt_d[k]   = ONE_C;
                        end
                    end else if (state_q[k] == S_HELD) begin
                        if (REPEAT_DELAY > 0 && cnt_q[k] == RD_C) begin
                            state_d[k]  = S_REPEAT;
                            cnt_d[k]    = '0;
                            repeat_d[k] = 1'b1;
                        end else begin
                            cnt_d[k] = sat_inc(cnt_q[k]);
                        end
                    end else begin
                        if (cnt_q[k] == RP_C) begin
                            cnt_d[k]    = '0;
                            repeat_d[k] = 1'b1;
                        end else begin
                            cnt_d[k] = sat_inc(cnt_q[k]);
                        end
                    end
                end
                S_RELEASE_CHK: begin
                    if (!key_n_in[k]) begin
                        // Bounce back to held restarts the repeat delay.
                        state_d[k] = S_HELD;
                        cnt_d[k]   = '0;
                    end else if (sat_inc(cnt_q[k]) >= DEB_C) begin
                        state_d[k]   = S_IDLE;
                        cnt_d[k]     = '0;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = sat_inc(cnt_q[k]);
                    end
                end
                default: begin
                    state_d[k] = S_IDLE;
                    cnt_d[k]   = '0;
                end
            endcase
            key_n_d[k] = !(state_d[k] == S_HELD || state_d[k] == S_REPEAT ||
                           state_d[k] == S_RELEASE_CHK);
        end
        any_key_d = ~&key_n_d;
        pause_n_d = pause_n_q ^ press_d[PAUSE_KEY];
    end

    // State, counter and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= S_IDLE;
                cnt_q[k]   <= '0;
            end
            key_n_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            pause_n_q <= 1'b1;
            any_key_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            key_n_q   <= key_n_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            pause_n_q <= pause_n_d;
            any_key_q <= any_key_d;
        end
    end

    assign key_n_out   = key_n_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign repeat_o    = repeat_q;
    assign pause_n_out = pause_n_q;
    assign any_key     = any_key_q;

endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed bench for key_ctrl with short debounce/repeat timing.
module tb_key_ctrl;
    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n_in;
    logic [NK-1:0] key_n_out;
    logic [NK-1:0] press_o;
    logic [NK-1:0] release_o;
    logic [NK-1:0] repeat_o;
    logic          pause_n_out;
    logic          any_key;

    int checks   = 0;
    int failures = 0;

    key_ctrl #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3),
        .PAUSE_KEY(1),
        .CW(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n_in(key_n_in),
        .key_n_out(key_n_out),
        .press_o(press_o),
        .release_o(release_o),
        .repeat_o(repeat_o),
        .pause_n_out(pause_n_out),
        .any_key(any_key)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_keyn"},  32'(key_n_out),   32'hF);
        check_val({tag, "_press"}, 32'(press_o),     32'h0);
        check_val({tag, "_rel"},   32'(release_o),   32'h0);
        check_val({tag, "_rep"},   32'(repeat_o),    32'h0);
        check_val({tag, "_pause"}, 32'(pause_n_out), 32'h1);
        check_val({tag, "_any"},   32'(any_key),     32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        key_n_in = '1;
        tick();
        check_idle_outputs("rst");

        // Keys low while reset is held: reset must win.
        key_n_in = 4'b0000;
        for (int i = 1; i <= 6; i++) tick();
        check_idle_outputs("rst_override");
        key_n_in = '1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_idle_outputs("post_rst");

        // Clean press of key 0 with auto-repeat at +10, +13, +16.
        key_n_in[0] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_val($sformatf("t1_press c%0d", i), 32'(press_o[0]), 32'(i == 4));
            check_val($sformatf("t1_rep c%0d", i), 32'(repeat_o[0]),
                      32'(i == 4 || i == 14 || i == 17 || i == 20));
            check_val($sformatf("t1_keyn c%0d", i), 32'(key_n_out[0]), 32'(i < 4));
            check_val($sformatf("t1_any c%0d", i), 32'(any_key), 32'(i >= 4));
            check_val($sformatf("t1_pause c%0d", i), 32'(pause_n_out), 32'h1);
        end
        key_n_in[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("t1_rel c%0d", i), 32'(release_o[0]), 32'(i == 4));
            check_val($sformatf("t1_relrep c%0d", i), 32'(repeat_o[0]), 32'h0);
            check_val($sformatf("t1_relkeyn c%0d", i), 32'(key_n_out[0]), 32'(i >= 4));
        end

        // Bouncing key 2 never reaches the debounce count.
        for (int i = 1; i <= 24; i++) begin
            key_n_in[2] = (i > 20) ? 1'b1 : (((i - 1) % 4) == 3);
            tick();
            check_val($sformatf("t2_keyn c%0d", i), 32'(key_n_out[2]), 32'h1);
            check_val($sformatf("t2_strb c%0d", i),
                      32'({press_o[2], release_o[2], repeat_o[2]}), 32'h0);
        end

        // Release glitch on key 3 restarts the repeat delay.
        for (int i = 1; i <= 22; i++) begin
            key_n_in[3] = (i == 8 || i == 9);
            tick();
            check_val($sformatf("t3_press c%0d", i), 32'(press_o[3]), 32'(i == 4));
            check_val($sformatf("t3_rep c%0d", i), 32'(repeat_o[3]), 32'(i == 4 || i == 20));
            check_val($sformatf("t3_rel c%0d", i), 32'(release_o[3]), 32'h0);
            check_val($sformatf("t3_keyn c%0d", i), 32'(key_n_out[3]), 32'(i < 4));
        end
        key_n_in[3] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("t3_relend c%0d", i), 32'(release_o[3]), 32'(i == 4));
        end

        // Pause toggles on press strobes of key 1 only.
        key_n_in[1] = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_val($sformatf("t4_rep c%0d", i), 32'(repeat_o[1]), 32'(i == 4 || i == 14));
            check_val($sformatf("t4_pause c%0d", i), 32'(pause_n_out), 32'(i < 4));
        end
        key_n_in[1] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("t4_rel c%0d", i), 32'(release_o[1]), 32'(i == 4));
            check_val($sformatf("t4_relpause c%0d", i), 32'(pause_n_out), 32'h0);
        end
        key_n_in[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val($sformatf("t4_press2 c%0d", i), 32'(press_o[1]), 32'(i == 4));
            check_val($sformatf("t4_pause2 c%0d", i), 32'(pause_n_out), 32'(i >= 4));
        end
        key_n_in[1] = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        check_val("t4_final_pause", 32'(pause_n_out), 32'h1);

        // Simultaneous presses and releases on keys 0 and 3.
        key_n_in = 4'b0110;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("t5_press c%0d", i), 32'(press_o), (i == 4) ? 32'h9 : 32'h0);
            check_val($sformatf("t5_any c%0d", i), 32'(any_key), 32'(i >= 4));
        end
        check_val("t5_keyn_held", 32'(key_n_out), 32'h6);
        key_n_in = 4'b1111;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("t5_rel c%0d", i), 32'(release_o), (i == 4) ? 32'h9 : 32'h0);
            check_val($sformatf("t5_relany c%0d", i), 32'(any_key), 32'(i < 4));
        end

        // Reset while keys 0 and 1 are repeating.
        key_n_in = 4'b1100;
        for (int i = 1; i <= 18; i++) begin
            tick();
            check_val($sformatf("t6_press c%0d", i), 32'(press_o), (i == 4) ? 32'h3 : 32'h0);
            check_val($sformatf("t6_rep c%0d", i), 32'(repeat_o),
                      (i == 4 || i == 14 || i == 17) ? 32'h3 : 32'h0);
            check_val($sformatf("t6_pause c%0d", i), 32'(pause_n_out), 32'(i < 4));
        end
        reset = 1'b1;
        tick();
        check_idle_outputs("t6_rst");
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("t6_repress c%0d", i), 32'(press_o), (i == 4) ? 32'h3 : 32'h0);
            check_val($sformatf("t6_rekeyn c%0d", i), 32'(key_n_out), (i < 4) ? 32'hF : 32'hC);
            check_val($sformatf("t6_repause c%0d", i), 32'(pause_n_out), 32'(i < 4));
        end
        key_n_in = 4'b1111;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("t6_rel c%0d", i), 32'(release_o), (i == 4) ? 32'h3 : 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
